// File: rtl/uart_ins_loader.sv
// 8N1 UART receiver that packs four bytes (big-endian) into an instruction word
// and strobes it with an auto-incrementing address. Optional macro: UART_INS_LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_ins_loader #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  output logic [31:0]       W_Ins,
  output logic              WE,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              BUSY,
  output logic              FERR
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2 - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_ins_loader: CLK_HZ/BAUD must be at least 4");
  end
  if (TIMEOUT_BITS < 1) begin : g_bad_timeout
    $error("uart_ins_loader: TIMEOUT_BITS must be positive");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_s1, rx_s2, rx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [1:0]       byte_idx;
  logic [23:0]      shadow;
  logic             half_hit, full_hit;
  logic             cnt_clr, start_det, start_ok, bit_shift, byte_done, frame_err;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RXD;
      rx_s2 <= rx_s1;
    end
  end
  assign rx = rx_s2;

  assign half_hit = (cnt == HALF);
  assign full_hit = (cnt == FULL);

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx) state_nxt = START;
      START: if (half_hit) state_nxt = rx ? IDLE : DATA;
      DATA:  if (full_hit && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (full_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    start_det = 1'b0;
    start_ok  = 1'b0;
    bit_shift = 1'b0;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr   = 1'b1;
        start_det = !rx;
      end
      START: begin
        cnt_clr  = half_hit;
        start_ok = half_hit && !rx;
      end
      DATA: begin
        cnt_clr   = full_hit;
        bit_shift = full_hit;
      end
      STOP: begin
        cnt_clr   = full_hit;
        byte_done = full_hit && rx;
        frame_err = full_hit && !rx;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

`ifdef UART_INS_LOADER_TIMEOUT_EN
  localparam int TO_LIM = TIMEOUT_BITS * CPB;
  localparam int TO_W   = $clog2(TO_LIM + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            idle_wait, timeout_hit;

  assign idle_wait   = (state == IDLE) && (byte_idx != 2'd0);
  assign timeout_hit = idle_wait && rx && (idle_cnt == TO_W'(TO_LIM - 1));

  always_ff @(posedge CLK) begin
    if (!RST || start_det || !idle_wait || timeout_hit) idle_cnt <= '0;
    else                                                idle_cnt <= idle_cnt + 1'b1;
  end
`endif

  // WE is a one-cycle strobe with no back-pressure: W_Ins/W_Addr are valid
  // only while it is high, and the address advances on the following cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      byte_idx <= '0;
      shadow   <= '0;
      W_Ins    <= '0;
      WE       <= 1'b0;
      W_Addr   <= '0;
      FERR     <= 1'b0;
    end else begin
      WE  <= 1'b0;
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (WE) W_Addr <= W_Addr + 1'b1;
      if (start_ok)       bit_idx <= '0;
      else if (bit_shift) bit_idx <= bit_idx + 1'b1;
      if (bit_shift) shift <= {rx, shift[7:1]};
      if (frame_err) FERR <= 1'b1;
      if (byte_done) begin
        case (byte_idx)
          2'd0: shadow[23:16] <= shift;
          2'd1: shadow[15:8]  <= shift;
          2'd2: shadow[7:0]   <= shift;
          default: begin
            W_Ins <= {shadow, shift};
            WE    <= 1'b1;
          end
        endcase
        byte_idx <= byte_idx + 1'b1;
      end
`ifdef UART_INS_LOADER_TIMEOUT_EN
      if (timeout_hit) begin
        byte_idx <= '0;
        shadow   <= '0;
      end
`endif
    end
  end

  assign BUSY = (state != IDLE) || (byte_idx != 2'd0);

endmodule

// File: tb/tb_uart_ins_loader.sv
// Randomized bench for uart_ins_loader: a byte/word-level reference model
// predicts every write strobe, the sticky error flag and the busy level.
`timescale 1ns/1ps
module tb_uart_ins_loader;

  localparam int CLK_HZ       = 1000000;
  localparam int BAUD         = 100000;
  localparam int ADDR_W       = 4;
  localparam int TIMEOUT_BITS = 20;
  localparam int CPB          = CLK_HZ / BAUD;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rxd = 1'b1;
  logic [31:0]       w_ins;
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic              busy;
  logic              ferr;

  uart_ins_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .CLK(clk), .RST(rst), .RXD(rxd), .W_Ins(w_ins), .WE(we),
    .W_Addr(w_addr), .BUSY(busy), .FERR(ferr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // reference model: bytes -> words -> expected {addr, word} strobes
  logic [7:0]          part_q[$];
  logic [ADDR_W+31:0]  exp_q[$];
  logic [ADDR_W-1:0]   m_addr = '0;
  logic                m_ferr = 1'b0;
  logic [31:0]         m_last = '0;

  task automatic model_good(input logic [7:0] b);
    logic [31:0] word;
    part_q.push_back(b);
    if (part_q.size() == 4) begin
      word = {part_q[0], part_q[1], part_q[2], part_q[3]};
      exp_q.push_back({m_addr, word});
      m_addr = m_addr + 1'b1;
      m_last = word;
      part_q.delete();
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    m_addr = '0;
    m_ferr = 1'b0;
    m_last = '0;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap_bits);
    if (stop) model_good(b);
    else      m_ferr = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (gap_bits * CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
`ifdef UART_INS_LOADER_TIMEOUT_EN
    if (n > TIMEOUT_BITS) part_q.delete();
`endif
    rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_w_ins", w_ins, 32'd0);
    check("rst_we", we, 32'd0);
    check("rst_w_addr", w_addr, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ferr", ferr, 32'd0);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_busy"}, busy, (part_q.size() != 0));
    check({tag, "_ferr"}, ferr, m_ferr);
    check({tag, "_w_ins"}, w_ins, m_last);
    check({tag, "_w_addr"}, w_addr, m_addr);
  endtask

  // scoreboard: every WE must match the head of the expected queue
  logic               pend = 1'b0;
  logic [ADDR_W-1:0]  pend_addr_n;
  logic [ADDR_W+31:0] mon_e;

  always @(negedge clk) begin
    if (pend) begin
      check("we_one_cycle", we, 32'd0);
      check("addr_inc", w_addr, pend_addr_n);
      pend = 1'b0;
    end
    if (we) begin
      check("busy_at_we", busy, 32'd0);
      check("we_expected", (exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("w_ins", w_ins, mon_e[31:0]);
        check("w_addr", w_addr, mon_e[ADDR_W+31:32]);
      end
      pend = 1'b1;
      pend_addr_n = w_addr + 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    logic [7:0] b;
    logic stop;
    repeat (3) @(negedge clk);
    do_reset();

    // single word
    send_byte(8'h20, 1'b1, 1);
    send_byte(8'h08, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h05, 1'b1, 1);
    drain("single");

    // 17 random words back-to-back, address wraps on the 17th
    do_reset();
    for (int w = 0; w < 17; w++)
      for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b1, 1);
    drain("wrap");

    // framing error then a good word
    do_reset();
    send_byte(8'h8C, 1'b0, 2);
    send_byte(8'hAC, 1'b1, 1);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h04, 1'b1, 1);
    drain("ferr");

    // 3-cycle glitch while idle
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch_busy_low", busy, 32'd0);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) hi++;
    end
    check("glitch_stay_idle", hi, 32'd0);
    drain("glitch");

    // reset discards a partial word
    send_byte(8'h5A, 1'b1, 1);
    send_byte(8'hA5, 1'b1, 1);
    do_reset();
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h08, 1'b1, 1);
    drain("rst_partial");

    // long idle gap inside a word
    do_reset();
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 0);
    idle_bits(25);
    send_byte(8'h33, 1'b1, 1);
    send_byte(8'h44, 1'b1, 1);
    send_byte(8'h55, 1'b1, 1);
    send_byte(8'h66, 1'b1, 1);
    drain("idle_gap");

    // random bytes, gaps and occasional framing errors
    do_reset();
    for (int i = 0; i < 28; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_byte(b, stop, stop ? $urandom_range(1, 3) : $urandom_range(2, 3));
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
